// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch unit: fetch PC, one outstanding request, DEPTH-entry {addr, inst} FIFO
// A redirect empties the FIFO and, if a response is still in flight, spends one FLUSH cycle swallowing it.
module ifu_prefetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state, state_nx;
  logic [31:0]   pc;
  logic [31:0]   pend_addr;
  logic          pending;
  logic [31:0]   fifo_addr [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] occ;
  logic          pop, push, issue, not_empty;

  assign not_empty    = (count != '0);
  assign inst_valid_o = not_empty & ~jump_en_i;
  assign inst_o       = not_empty ? fifo_inst[rd_ptr] : NOP_INST;
  assign inst_addr_o  = not_empty ? fifo_addr[rd_ptr] : 32'h0;
  assign rom_addr_o   = pc;

  assign pop   = inst_valid_o & inst_ready_i;
  // Occupancy once this cycle's pop and the in-flight word are accounted for.
  assign occ   = count + CW'(pending) - CW'(pop);
  assign issue = rom_req_o & rom_gnt_i;
  // pending is cleared on a redirect, so a stale word arriving in FLUSH is never pushed.
  assign push  = rom_rvalid_i & pending & ~jump_en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rom_req_o = 1'b0;
    case (state)
      RUN: begin
        rom_req_o = ~rst & ~jump_en_i & (occ < CW'(DEPTH));
        if (jump_en_i && pending) state_nx = FLUSH;
      end
      FLUSH:   state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_ADDR;
      pend_addr <= 32'h0;
      pending   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (jump_en_i) begin
      pc      <= jump_addr_i & 32'hFFFF_FFFC;
      pending <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (issue) begin
        pc        <= pc + 32'd4;
        pend_addr <= pc;
        pending   <= 1'b1;
      end else if (push) begin
        pending <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= pend_addr;
      fifo_inst[wr_ptr] <= rom_rdata_i;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && count == CW'(DEPTH)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed and randomized checks of ifu_prefetch against a queue-based reference model
module tb_ifu_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [31:0] inst, inst_addr;
  logic        inst_valid;
  logic        ready = 1'b0;
  logic        inject = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: fetch PC, queue of delivered-but-unconsumed {addr, data}, in-flight request, flush flag.
  logic [31:0] mpc = RST_A;
  logic [63:0] q[$];
  bit          inflight = 1'b0;
  logic [31:0] inflight_addr = 32'h0;
  bit          flush = 1'b0;

  always #5 clk = ~clk;

  ifu_prefetch #(.RESET_ADDR(RST_A), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_gnt_i(gnt),
    .rom_rvalid_i(rvalid), .rom_rdata_i(rdata),
    .inst_o(inst), .inst_addr_o(inst_addr), .inst_valid_o(inst_valid),
    .inst_ready_i(ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model, play the memory side across the edge.
  task automatic cycle();
    int          n;
    bit          pop_m, req_m, nv;
    logic [31:0] nd;
    #1;
    if (rst) begin
      chk("rst_req", 32'(rom_req), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, NOP);
      chk("rst_iaddr", inst_addr, 32'h0);
      chk("rst_pc", rom_addr, RST_A);
      mpc = RST_A; q.delete(); inflight = 1'b0; flush = 1'b0;
    end else begin
      n     = q.size();
      pop_m = (n != 0) && !jump_en && ready;
      req_m = !jump_en && !flush && ((n + int'(inflight) - int'(pop_m)) < DEPTH);
      chk("req", 32'(rom_req), 32'(req_m));
      chk("rom_addr", rom_addr, mpc);
      chk("valid", 32'(inst_valid), 32'((n != 0) && !jump_en));
      chk("inst", inst, (n != 0) ? q[0][31:0] : NOP);
      chk("iaddr", inst_addr, (n != 0) ? q[0][63:32] : 32'h0);
      if (jump_en) begin
        q.delete();
        flush    = inflight;
        inflight = 1'b0;
        mpc      = jump_addr & 32'hFFFF_FFFC;
      end else begin
        if (pop_m) void'(q.pop_front());
        if (rvalid && inflight) q.push_back({inflight_addr, rdata});
        flush = 1'b0;
        if (req_m && gnt) begin
          inflight = 1'b1; inflight_addr = mpc; mpc = mpc + 32'd4;
        end else if (rvalid) begin
          inflight = 1'b0;
        end
      end
    end
    nv = (rom_req & gnt) | inject;
    nd = inject ? 32'hDEAD_BEEF : rom_addr + 32'h100;
    @(posedge clk);
    #1;
    rvalid = nv;
    rdata  = nd;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] iss [2];
    int          got;

    @(negedge clk);
    rst = 1'b1; gnt = 1'b1; ready = 1'b1;
    cycle(); cycle();
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    rst = 1'b0;

    // Reset release: spurious rvalid ignored, fetch 0,4,8.., first instruction in cycle 2.
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("r20_rom_addr", rom_addr, 32'(4 * k));
      if (k < 2) chk("r20_no_valid", 32'(inst_valid), 32'd0);
      if (k == 2) begin
        chk("r20_first_valid", 32'(inst_valid), 32'd1);
        chk("r20_first_inst", inst, 32'h100);
        chk("r20_first_iaddr", inst_addr, 32'h0);
      end
      cycle();
    end

    // Back-pressure fills the FIFO and stops requests, then drains in order.
    ready = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    #1;
    chk("r21_req_drop", 32'(rom_req), 32'd0);
    chk("r21_full_valid", 32'(inst_valid), 32'd1);
    ready = 1'b1;
    for (int k = 0; k < 10; k++) cycle();

    // Redirect with a request pending.
    jump_en = 1'b1; jump_addr = 32'h0000_0203;
    #1;
    chk("r22_jump_valid", 32'(inst_valid), 32'd0);
    chk("r22_jump_req", 32'(rom_req), 32'd0);
    cycle();
    jump_en = 1'b0;
    #1;
    chk("r22_flush_req", 32'(rom_req), 32'd0);
    chk("r22_flush_valid", 32'(inst_valid), 32'd0);
    chk("r22_flush_pc", rom_addr, 32'h200);
    cycle();
    #1;
    chk("r22_refetch_req", 32'(rom_req), 32'd1);
    chk("r22_refetch_addr", rom_addr, 32'h200);
    cycle(); cycle();
    #1;
    chk("r22_first_valid", 32'(inst_valid), 32'd1);
    chk("r22_first_iaddr", inst_addr, 32'h200);
    chk("r22_first_inst", inst, 32'h300);

    // Grant toggling: address holds while gnt is low.
    held = 32'h0;
    for (int k = 0; k < 8; k++) begin
      gnt = (k % 2 == 0) ? 1'b0 : 1'b1;
      #1;
      if (gnt) chk("r23_hold", rom_addr, held);
      else held = rom_addr;
      cycle();
    end
    gnt = 1'b1;

    // Wrap at the top of the address space.
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
    cycle();
    jump_en = 1'b0;
    got = 0;
    for (int k = 0; k < 6 && got < 2; k++) begin
      #1;
      if (rom_req && gnt) begin
        iss[got] = rom_addr;
        got++;
      end
      cycle();
    end
    chk("r24_fetches", 32'(got), 32'd2);
    if (got == 2) begin
      chk("r24_fetch0", iss[0], 32'hFFFF_FFFC);
      chk("r24_fetch1", iss[1], 32'h0000_0000);
    end
    for (int k = 0; k < 4; k++) cycle();

    // Reset mid-fetch with two entries held and one request pending.
    ready = 1'b0;
    cycle();
    chk("r25_pre_count", 32'(q.size()), 32'd2);
    chk("r25_pre_pending", 32'(inflight), 32'd1);
    rst = 1'b1;
    #1;
    chk("r25_req", 32'(rom_req), 32'd0);
    chk("r25_valid", 32'(inst_valid), 32'd0);
    chk("r25_inst", inst, NOP);
    chk("r25_iaddr", inst_addr, 32'h0);
    cycle(); cycle();
    rst = 1'b0; ready = 1'b1;
    #1;
    chk("r25_restart_req", 32'(rom_req), 32'd1);
    chk("r25_restart_addr", rom_addr, RST_A);
    cycle();

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      gnt       = ($urandom_range(0, 3) != 0);
      ready     = ($urandom_range(0, 3) != 0);
      jump_en   = ($urandom_range(0, 15) == 0);
      jump_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom();
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; jump_en = 1'b0; gnt = 1'b1; ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
